// File: rtl/tmc_uart.sv
// tmc_uart - half-duplex single-wire UART master for a TMC stepper driver.
//
// Sends one register read or write datagram per request: sync byte 0x05,
// slave, register, optional 32-bit data, and CRC8. For reads it then
// releases the line, receives the 8-byte reply, checks it and returns the
// register value.
//
// Build option: define TMC_UART_CRC_CHECK_EN to make a reply CRC mismatch
// an error. Without it the reply CRC byte is received and ignored.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid/req_ready    request handshake (ready = idle)
//   req_write              1 = write datagram, 0 = read request
//   req_slave, req_reg     TMC slave and register address
//   req_data               write data
//   rsp_valid              one-cycle completion pulse
//   rsp_data, rsp_error    read value / error flag, held until next accept
//   busy                   transaction in progress
//   uart_in                pad input (asynchronous)
//   uart_out, uart_oe      pad drive value and drive enable
module tmc_uart #(
  parameter int HZ           = 24000000,
  parameter int BAUD         = 250000,
  parameter int TIMEOUT_BITS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_slave,
  input  logic [6:0]  req_reg,
  input  logic [31:0] req_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_error,
  output logic        busy,
  input  logic        uart_in,
  output logic        uart_out,
  output logic        uart_oe
);
  localparam int DIV       = HZ / BAUD;
  localparam int DW        = $clog2(DIV);
  localparam int TO_CYCLES = TIMEOUT_BITS * DIV;
  localparam int TW        = $clog2(TO_CYCLES + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [DW-1:0] DIV_MID  = DW'(DIV / 2 - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TO_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, TX_BYTE, RX_WAIT, RX_BYTE, DONE} state_t;

  state_t       state_reg, state_next;
  logic [DW-1:0] div_cnt_reg, div_cnt_next;
  logic [3:0]   bit_cnt_reg, bit_cnt_next;
  logic [2:0]   byte_idx_reg, byte_idx_next;
  logic [2:0]   last_idx_reg, last_idx_next;
  logic         write_reg, write_next;
  logic [6:0]   reg_addr_reg, reg_addr_next;
  logic [63:0]  tx_frame_reg, tx_frame_next;   // current byte in [63:56]
  logic [9:0]   tx_shift_reg, tx_shift_next;   // bit 0 drives the line
  logic [7:0]   crc_reg, crc_next;
  logic         oe_reg, oe_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [7:0]   rx_shift_reg, rx_shift_next;
  logic [31:0]  rx_data_reg, rx_data_next;
  logic         hdr_err_reg, hdr_err_next;
  logic         rsp_valid_reg, rsp_valid_next;
  logic [31:0]  rsp_data_reg, rsp_data_next;
  logic         rsp_error_reg, rsp_error_next;
  logic         sync1_reg, sync2_reg, rx_prev_reg;

  logic         div_wrap, rx_fall, rx_err;
  logic [7:0]   crc_tx, crc_rx;
  logic [63:0]  frame_shift;

  function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in, input logic [7:0] data);
    logic [7:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[7] ^ data[i]) c = {c[6:0], 1'b0} ^ 8'h07;
      else                c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      div_cnt_reg   <= '0;
      bit_cnt_reg   <= '0;
      byte_idx_reg  <= '0;
      last_idx_reg  <= '0;
      write_reg     <= 1'b0;
      reg_addr_reg  <= '0;
      tx_frame_reg  <= '0;
      tx_shift_reg  <= '1;
      crc_reg       <= '0;
      oe_reg        <= 1'b0;
      timer_reg     <= '0;
      rx_shift_reg  <= '0;
      rx_data_reg   <= '0;
      hdr_err_reg   <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_error_reg <= 1'b0;
      sync1_reg     <= 1'b1;
      sync2_reg     <= 1'b1;
      rx_prev_reg   <= 1'b1;
    end else begin
      state_reg     <= state_next;
      div_cnt_reg   <= div_cnt_next;
      bit_cnt_reg   <= bit_cnt_next;
      byte_idx_reg  <= byte_idx_next;
      last_idx_reg  <= last_idx_next;
      write_reg     <= write_next;
      reg_addr_reg  <= reg_addr_next;
      tx_frame_reg  <= tx_frame_next;
      tx_shift_reg  <= tx_shift_next;
      crc_reg       <= crc_next;
      oe_reg        <= oe_next;
      timer_reg     <= timer_next;
      rx_shift_reg  <= rx_shift_next;
      rx_data_reg   <= rx_data_next;
      hdr_err_reg   <= hdr_err_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_data_reg  <= rsp_data_next;
      rsp_error_reg <= rsp_error_next;
      sync1_reg     <= uart_in;
      sync2_reg     <= sync1_reg;
      rx_prev_reg   <= sync2_reg;
    end
  end

  always_comb begin
    state_next     = state_reg;
    div_cnt_next   = div_cnt_reg;
    bit_cnt_next   = bit_cnt_reg;
    byte_idx_next  = byte_idx_reg;
    last_idx_next  = last_idx_reg;
    write_next     = write_reg;
    reg_addr_next  = reg_addr_reg;
    tx_frame_next  = tx_frame_reg;
    tx_shift_next  = tx_shift_reg;
    crc_next       = crc_reg;
    oe_next        = oe_reg;
    timer_next     = timer_reg;
    rx_shift_next  = rx_shift_reg;
    rx_data_next   = rx_data_reg;
    hdr_err_next   = hdr_err_reg;
    rsp_valid_next = 1'b0;
    rsp_data_next  = rsp_data_reg;
    rsp_error_next = rsp_error_reg;
    div_wrap       = (div_cnt_reg == DIV_LAST);
    rx_fall        = rx_prev_reg & ~sync2_reg;
    crc_tx         = crc8_byte(crc_reg, tx_frame_reg[63:56]);
    crc_rx         = crc8_byte(crc_reg, rx_shift_reg);
    frame_shift    = {tx_frame_reg[55:0], 8'h00};
    rx_err         = 1'b0;

    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          state_next     = TX_BYTE;
          write_next     = req_write;
          reg_addr_next  = req_reg;
          tx_frame_next  = req_write ? {8'h05, 6'b0, req_slave, 1'b1, req_reg, req_data, 8'h00}
                                     : {8'h05, 6'b0, req_slave, 1'b0, req_reg, 40'h0};
          tx_shift_next  = {1'b1, 8'h05, 1'b0};
          oe_next        = 1'b1;
          div_cnt_next   = '0;
          bit_cnt_next   = '0;
          byte_idx_next  = '0;
          last_idx_next  = req_write ? 3'd7 : 3'd3;
          crc_next       = '0;
          rsp_data_next  = '0;
          rsp_error_next = 1'b0;
        end
      end

      TX_BYTE: begin
        div_cnt_next = div_wrap ? '0 : div_cnt_reg + 1'b1;
        if (div_wrap) begin
          if (bit_cnt_reg != 4'd9) begin
            bit_cnt_next  = bit_cnt_reg + 1'b1;
            tx_shift_next = {1'b1, tx_shift_reg[9:1]};
          end else if (byte_idx_reg == last_idx_reg) begin
            // Last stop bit done: release the line and set up reception.
            oe_next       = 1'b0;
            tx_shift_next = '1;
            crc_next      = '0;
            byte_idx_next = '0;
            bit_cnt_next  = '0;
            timer_next    = '0;
            rx_data_next  = '0;
            hdr_err_next  = 1'b0;
            if (write_reg) begin
              state_next     = DONE;
              rsp_valid_next = 1'b1;
            end else begin
              state_next = RX_WAIT;
            end
          end else begin
            // Next byte follows with no gap; the final slot carries the CRC.
            crc_next      = crc_tx;
            byte_idx_next = byte_idx_reg + 1'b1;
            bit_cnt_next  = '0;
            if (3'(byte_idx_reg + 3'd1) == last_idx_reg) frame_shift[63:56] = crc_tx;
            tx_frame_next = frame_shift;
            tx_shift_next = {1'b1, frame_shift[63:56], 1'b0};
          end
        end
      end

      RX_WAIT: begin
        if (timer_reg != '1) timer_next = timer_reg + 1'b1;
        if (rx_fall) begin
          state_next   = RX_BYTE;
          div_cnt_next = '0;
          bit_cnt_next = '0;
        end else if (timer_reg >= TO_LAST) begin
          state_next     = DONE;
          rsp_valid_next = 1'b1;
          rsp_error_next = 1'b1;
          rsp_data_next  = '0;
        end
      end

      RX_BYTE: begin
        // Timer keeps running so a glitch does not extend the reply window.
        if (timer_reg != '1) timer_next = timer_reg + 1'b1;
        div_cnt_next = div_wrap ? '0 : div_cnt_reg + 1'b1;
        if (div_cnt_reg == DIV_MID) begin
          if (bit_cnt_reg == 4'd0) begin
            if (sync2_reg) state_next = RX_WAIT;
            else           bit_cnt_next = 4'd1;
          end else if (bit_cnt_reg != 4'd9) begin
            rx_shift_next = {sync2_reg, rx_shift_reg[7:1]};
            bit_cnt_next  = bit_cnt_reg + 1'b1;
          end else if (!sync2_reg) begin
            state_next     = DONE;
            rsp_valid_next = 1'b1;
            rsp_error_next = 1'b1;
            rsp_data_next  = '0;
          end else if (byte_idx_reg == 3'd7) begin
`ifdef TMC_UART_CRC_CHECK_EN
            rx_err = hdr_err_reg | (rx_shift_reg != crc_reg);
`else
            rx_err = hdr_err_reg;
`endif
            state_next     = DONE;
            rsp_valid_next = 1'b1;
            rsp_error_next = rx_err;
            rsp_data_next  = rx_err ? 32'h0 : rx_data_reg;
          end else begin
            crc_next = crc_rx;
            case (byte_idx_reg)
              3'd0:    if (rx_shift_reg != 8'h05) hdr_err_next = 1'b1;
              3'd1:    if (rx_shift_reg != 8'hFF) hdr_err_next = 1'b1;
              3'd2:    if (rx_shift_reg != {1'b0, reg_addr_reg}) hdr_err_next = 1'b1;
              default: rx_data_next = {rx_data_reg[23:0], rx_shift_reg};
            endcase
            byte_idx_next = byte_idx_reg + 1'b1;
            bit_cnt_next  = '0;
            timer_next    = '0;
            state_next    = RX_WAIT;
          end
        end
      end

      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign req_ready = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_error = rsp_error_reg;
  assign uart_out  = tx_shift_reg[0];
  assign uart_oe   = oe_reg;

endmodule

// File: tb/tb_tmc_uart.sv
// tb_tmc_uart - self-checking bench for tmc_uart (DIV = 96).
// A vector table drives requests; transmitted bytes and responses are
// checked against scoreboard queues filled when each request is issued.
module tb_tmc_uart;
  localparam int DIV      = 96;
  localparam int TO_BITS  = 64;
  localparam int MAX_WAIT = 30000;

  localparam int M_WRITE   = 0;
  localparam int M_OK      = 1;
  localparam int M_NOREPLY = 2;
  localparam int M_BADHDR  = 3;
  localparam int M_BADCRC  = 4;
  localparam int M_GLITCH  = 5;
  localparam int M_STOPERR = 6;

  typedef struct {
    logic        write;
    logic [1:0]  slave;
    logic [6:0]  addr;
    logic [31:0] data;
    int          mode;
    logic [31:0] rdata;
    logic        exp_err;
    logic [31:0] exp_data;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_slave = '0;
  logic [6:0]  req_reg = '0;
  logic [31:0] req_data = '0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_error;
  logic        busy;
  logic        uart_in = 1'b1;
  logic        uart_out;
  logic        uart_oe;

  always #5 clk = ~clk;

  tmc_uart #(.HZ(24000000), .BAUD(250000), .TIMEOUT_BITS(TO_BITS)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_slave(req_slave), .req_reg(req_reg), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error),
    .busy(busy), .uart_in(uart_in), .uart_out(uart_out), .uart_oe(uart_oe)
  );

  int          checks = 0;
  int          errors = 0;
  int          rsp_seen = 0;
  int          oe_cycles = 0;
  logic [7:0]  tx_exp[$];
  logic [32:0] rsp_exp[$];
  vec_t        vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] crc_of(input logic [63:0] msg, input int n);
    logic [7:0] crc;
    logic [7:0] cur;
    crc = 8'h00;
    for (int k = 0; k < n; k++) begin
      cur = msg[63-8*k -: 8];
      for (int i = 0; i < 8; i++) begin
        if (crc[7] ^ cur[i]) crc = (crc << 1) ^ 8'h07;
        else                 crc = crc << 1;
      end
    end
    return crc;
  endfunction

  function automatic vec_t mk(input logic w, input logic [1:0] s, input logic [6:0] a,
                              input logic [31:0] d, input int m, input logic [31:0] rd,
                              input logic ee, input logic [31:0] ed);
    vec_t v;
    v.write = w; v.slave = s; v.addr = a; v.data = d;
    v.mode = m; v.rdata = rd; v.exp_err = ee; v.exp_data = ed;
    return v;
  endfunction

  always @(negedge clk) if (uart_oe) oe_cycles++;

  // Decodes bytes on the driven line at mid-bit; aborts if the line is released.
  initial begin : tx_mon
    logic [7:0] b;
    logic [7:0] e;
    logic       stp;
    bit         ok;
    forever begin
      @(negedge clk);
      if (uart_oe === 1'b1 && uart_out === 1'b0) begin
        ok = 1'b1;
        for (int k = 0; k < DIV/2 && ok; k++) begin @(negedge clk); if (!uart_oe) ok = 1'b0; end
        for (int i = 0; i < 8; i++) begin
          for (int k = 0; k < DIV && ok; k++) begin @(negedge clk); if (!uart_oe) ok = 1'b0; end
          b[i] = uart_out;
        end
        for (int k = 0; k < DIV && ok; k++) begin @(negedge clk); if (!uart_oe) ok = 1'b0; end
        stp = uart_out;
        if (ok) begin
          if (tx_exp.size() == 0) begin
            checks++; errors++;
            $display("FAIL tx_unexpected: got byte 0x%02h expected none", b);
          end else begin
            e = tx_exp.pop_front();
            chk("tx_byte_stop", {23'b0, stp, b}, {23'b0, 1'b1, e});
          end
        end
      end
    end
  end

  initial begin : rsp_mon
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        rsp_seen++;
        if (rsp_exp.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp_unexpected: got data 0x%08h err %0b expected none", rsp_data, rsp_error);
        end else begin
          e = rsp_exp.pop_front();
          chk("rsp_data", rsp_data, e[31:0]);
          chk("rsp_error", {31'b0, rsp_error}, {31'b0, e[32]});
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_in = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_in = b[i];
      repeat (DIV) @(negedge clk);
    end
    uart_in = stop_bit;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic send_reply(input vec_t v);
    logic [63:0] r;
    r = {8'h05, 8'hFF, 1'b0, v.addr, v.rdata, 8'h00};
    if (v.mode == M_BADHDR) r[55:48] = 8'hFE;
    r[7:0] = crc_of(r, 7);
    if (v.mode == M_BADCRC) r[7:0] = r[7:0] ^ 8'h5A;
    if (v.mode == M_GLITCH) begin
      uart_in = 1'b0;
      @(negedge clk);
      uart_in = 1'b1;
      repeat (2*DIV) @(negedge clk);
    end
    for (int k = 0; k < 8; k++) begin
      if (v.mode == M_STOPERR && k == 1) begin
        send_byte(r[63-8*k -: 8], 1'b0);
        break;
      end
      send_byte(r[63-8*k -: 8], 1'b1);
    end
    uart_in = 1'b1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [63:0] msg;
    int n, cnt, base, t0;
    if (v.write) begin msg = {8'h05, 6'b0, v.slave, 1'b1, v.addr, v.data, 8'h00}; n = 7; end
    else         begin msg = {8'h05, 6'b0, v.slave, 1'b0, v.addr, 40'h0};         n = 3; end
    for (int k = 0; k < n; k++) tx_exp.push_back(msg[63-8*k -: 8]);
    tx_exp.push_back(crc_of(msg, n));
    rsp_exp.push_back({v.exp_err, v.exp_data});
    base = rsp_seen;
    t0   = oe_cycles;

    @(negedge clk);
    req_valid = 1'b1; req_write = v.write; req_slave = v.slave; req_reg = v.addr; req_data = v.data;
    @(negedge clk);
    chk("accept_busy", {31'b0, busy}, 32'd1);
    chk("accept_ready", {31'b0, req_ready}, 32'd0);
    chk("accept_oe_start", {30'b0, uart_oe, uart_out}, 32'd2);
    // A conflicting request while busy must be ignored.
    req_write = ~v.write; req_slave = ~v.slave; req_reg = ~v.addr; req_data = ~v.data;
    repeat (3) @(negedge clk);
    chk("busy_not_ready", {31'b0, req_ready}, 32'd0);
    req_valid = 1'b0;

    cnt = 0;
    while (uart_oe && cnt < MAX_WAIT) begin @(negedge clk); cnt++; end
    chk("line_released", {31'b0, uart_oe}, 32'd0);
    chk("release_out_high", {31'b0, uart_out}, 32'd1);

    if (!v.write && v.mode == M_NOREPLY) begin
      cnt = 0;
      while (!rsp_valid && cnt < MAX_WAIT) begin @(negedge clk); cnt++; end
      chk("timeout_latency", 32'(cnt), 32'(TO_BITS*DIV));
    end else if (!v.write) begin
      repeat (8*DIV) @(negedge clk);
      send_reply(v);
    end

    cnt = 0;
    while (rsp_seen == base && cnt < MAX_WAIT) begin @(negedge clk); cnt++; end
    chk("rsp_count", 32'(rsp_seen - base), 32'd1);
    @(negedge clk);
    chk("idle_ready", {31'b0, req_ready}, 32'd1);
    chk("oe_cycles", 32'(oe_cycles - t0), 32'((n + 1) * 10 * DIV));
    chk("tx_drained", 32'(tx_exp.size()), 32'd0);
    $display("vec %0d %s slave=%0d reg=0x%02h -> rsp data=0x%08h err=%0b",
             idx, v.write ? "write" : "read ", v.slave, v.addr, rsp_data, rsp_error);
  endtask

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [63:0] msg;
    int base;
    vecs[0] = mk(1'b1, 2'd0, 7'h00, 32'h0000_01C0, M_WRITE,   32'h0,         1'b0, 32'h0);
    vecs[1] = mk(1'b0, 2'd1, 7'h02, 32'h0,         M_OK,      32'h0000_0007, 1'b0, 32'h0000_0007);
    vecs[2] = mk(1'b0, 2'd3, 7'h6C, 32'h0,         M_NOREPLY, 32'h0,         1'b1, 32'h0);
    vecs[3] = mk(1'b0, 2'd2, 7'h11, 32'h0,         M_BADHDR,  32'hCAFE_0001, 1'b1, 32'h0);
`ifdef TMC_UART_CRC_CHECK_EN
    vecs[4] = mk(1'b0, 2'd1, 7'h22, 32'h0,         M_BADCRC,  32'h1234_5678, 1'b1, 32'h0);
`else
    vecs[4] = mk(1'b0, 2'd1, 7'h22, 32'h0,         M_BADCRC,  32'h1234_5678, 1'b0, 32'h1234_5678);
`endif
    vecs[5] = mk(1'b0, 2'd0, 7'h41, 32'h0,         M_GLITCH,  32'h00C0_FFEE, 1'b0, 32'h00C0_FFEE);
    vecs[6] = mk(1'b0, 2'd2, 7'h7F, 32'h0,         M_STOPERR, 32'hFFFF_FFFF, 1'b1, 32'h0);

    repeat (3) @(negedge clk);
    chk("reset_ready", {31'b0, req_ready}, 32'd1);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("reset_rsp_data", rsp_data, 32'd0);
    chk("reset_rsp_error", {31'b0, rsp_error}, 32'd0);
    chk("reset_line", {30'b0, uart_oe, uart_out}, 32'd1);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Reset asserted in the middle of byte 3 of a write.
    msg = {8'h05, 8'h01, 8'h90, 32'h1122_3344, 8'h00};
    for (int k = 0; k < 3; k++) tx_exp.push_back(msg[63-8*k -: 8]);
    base = rsp_seen;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_slave = 2'd1; req_reg = 7'h10; req_data = 32'h1122_3344;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (32*DIV) @(negedge clk);
    chk("pre_reset_oe", {31'b0, uart_oe}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_reset_line", {30'b0, uart_oe, uart_out}, 32'd1);
    chk("mid_reset_busy", {31'b0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    chk("reset_tx_prefix", 32'(tx_exp.size()), 32'd0);
    rst_n = 1'b1;
    $display("reset during write byte 3 -> line released, request dropped");
    run_vec(7, mk(1'b1, 2'd3, 7'h7F, 32'hA5A5_5A5A, M_WRITE, 32'h0, 1'b0, 32'h0));
    chk("reset_no_rsp", 32'(rsp_seen - base), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
